dc_fifo_rd_hyper: RTL

- Read-side endpoint of the hyperbus token-ring dual-clock FIFO. It runs entirely in the reader clock domain.
- It synchronises the writer's two-hot write token and detects empty.
- It selects the head entry from the shared data buffer using a one-hot read token, and presents that entry on a valid/ready interface.
- It exports its read token so the writer can detect full.

---
 rtl/dc_fifo_hyper_pkg.sv | 41 ++++
 rtl/dc_token_ring_hyper.sv | 32 +++
 rtl/dc_fifo_rd_hyper.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dc_fifo_hyper_pkg.sv
// Shared constants and token helpers for the hyperbus token-ring dual-clock FIFO.
// Tokens are handled at a fixed maximum width; callers zero-extend and slice.
package dc_fifo_hyper_pkg;

  localparam int TOK_MAX   = 64;
  localparam int TOK_IDX_W = 6;

  typedef logic [TOK_MAX-1:0]   tok_t;
  typedef logic [TOK_IDX_W-1:0] tok_idx_t;

  localparam tok_t WTOK_RESET = tok_t'(3);
  localparam tok_t RTOK_RESET = tok_t'(1);

  // Rotate the low n bits left by one: r[j] = x[(j-1) mod n]; bits >= n are zero.
  function automatic tok_t rotl1(input tok_t x, input int n);
    tok_t r;
    r = '0;
    for (int j = 0; j < TOK_MAX; j++) begin
      if (j < n) begin
        if (j == 0) begin
          r[j] = x[n-1];
        end else begin
          r[j] = x[j-1];
        end
      end
    end
    return r;
  endfunction

  function automatic tok_idx_t onehot_to_idx(input tok_t x);
    tok_idx_t idx;
    idx = '0;
    for (int j = 0; j < TOK_MAX; j++) begin
      if (x[j]) begin
        idx = idx | tok_idx_t'(j);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dc_token_ring_hyper.sv
// One-hot token ring register: rotates left by one slot on each enabled clock.
module dc_token_ring_hyper #(
  parameter int         N           = 8,
  parameter logic [N-1:0] RESET_VALUE = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en_i,
  output logic [N-1:0] token_o
);

  logic [N-1:0] token_q;
  logic [N-1:0] token_d;

  always_comb begin
    token_d = token_q;
    if (en_i) begin
      token_d = {token_q[N-2:0], token_q[N-1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      token_q <= RESET_VALUE;
    end else begin
      token_q <= token_d;
    end
  end

  assign token_o = token_q;

endmodule

// File: rtl/dc_fifo_rd_hyper.sv
// Read-side endpoint of the hyperbus token-ring dual-clock FIFO (reader clock only).
// Define DC_FIFO_RD_HYPER_OUTREG_EN to add a one-entry registered output stage.
module dc_fifo_rd_hyper
  import dc_fifo_hyper_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [BUFFER_DEPTH*DATA_WIDTH-1:0] data_i,
  input  logic [BUFFER_DEPTH-1:0]            write_token_i,
  output logic [BUFFER_DEPTH-1:0]            read_token_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o
);

  localparam int N     = BUFFER_DEPTH;
  localparam int IDX_W = $clog2(N);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = write_token_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= WTOK_RESET[N-1:0];
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  logic [N-1:0]         wtok_s;
  logic [N-1:0]         wlow;
  logic                 empty;
  tok_t                 wtok_ext;
  tok_t                 wrot_ext;
  tok_t                 rtok_ext;
  tok_idx_t             idx_full;
  logic [IDX_W-1:0]     rd_idx;
  logic [TOK_MAX-1:N]   unused_wrot;
  logic [TOK_IDX_W-1:IDX_W] unused_idx;

  assign wtok_s = sync_q[SYNC_STAGES-1];

  // Only the lower hot bit marks the writer's next slot; matching the upper
  // bit alone means the writer is N-1 entries ahead, which is not empty.
  always_comb begin
    wtok_ext         = '0;
    wtok_ext[N-1:0]  = wtok_s;
    wrot_ext         = rotl1(wtok_ext, N);
    wlow             = wtok_s & ~wrot_ext[N-1:0];
    empty            = |(read_token_o & wlow);
    rtok_ext         = '0;
    rtok_ext[N-1:0]  = read_token_o;
    idx_full         = onehot_to_idx(rtok_ext);
    rd_idx           = idx_full[IDX_W-1:0];
  end

  assign unused_wrot = wrot_ext[TOK_MAX-1:N];
  assign unused_idx  = idx_full[TOK_IDX_W-1:IDX_W];

  logic [DATA_WIDTH-1:0] entry [N];
  logic [DATA_WIDTH-1:0] head;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      assign entry[gi] = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign head = entry[rd_idx];

  logic pop;

  dc_token_ring_hyper #(
    .N           (N),
    .RESET_VALUE (RTOK_RESET[N-1:0])
  ) u_rtok (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (pop),
    .token_o (read_token_o)
  );

`ifdef DC_FIFO_RD_HYPER_OUTREG_EN
  logic                  valid_q;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // The stage pops the ring whenever it can take a new head entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pop     = ~empty & (~valid_q | ready_i);
    if (pop) begin
      valid_d = 1'b1;
      data_d  = head;
    end else if (ready_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
`else
  assign valid_o = ~empty;
  assign data_o  = head;
  assign pop     = valid_o & ready_i;
`endif

endmodule
